countdown_timer_dp: RTL and testbench

//  Countdown-timer datapath, the down-counting counterpart of the stopwatch datapath.
//  - Operator loads a preset H:M:S with inc/dec keys.
//  - The block counts down at 100 Hz centisecond resolution and flags expiry at 00:00:00.00.
//  - Outputs feed the FND controller with the same field widths as the stopwatch.
//  - Inputs come from the control unit (debounced, single-cycle key pulses).

---
 rtl/countdown_timer_dp_pkg.sv | 46 ++++
 rtl/countdown_timer_dp_prescaler.sv | 32 +++
 rtl/countdown_timer_dp.sv | 161 ++++++++++++++++
 tb/tb_countdown_timer_dp.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_dp_pkg.sv
`default_nettype none
// ============================================================================
// Package : countdown_timer_dp_pkg
// Shared state encodings, field moduli/widths and helpers for the countdown timer.
// Rev     : 1.0
// ============================================================================
package countdown_timer_dp_pkg;

    typedef enum logic [1:0] {
        CDT_IDLE    = 2'd0,
        CDT_RUN     = 2'd1,
        CDT_PAUSE   = 2'd2,
        CDT_EXPIRED = 2'd3
    } cdt_state_e;

    localparam int CS_MOD   = 100;
    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;

    localparam int CS_W   = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [CS_W-1:0]   CS_MAX   = CS_W'(CS_MOD - 1);
    localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(SEC_MOD - 1);
    localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(MIN_MOD - 1);
    localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOUR_MOD - 1);

    localparam logic [1:0] SEL_SEC  = 2'd0;
    localparam logic [1:0] SEL_MIN  = 2'd1;
    localparam logic [1:0] SEL_HOUR = 2'd2;

    // Wrapping +/-1 of an edit field whose largest legal value is vmax.
    function automatic logic [5:0] field_step(input logic [5:0] v,
                                              input logic [5:0] vmax,
                                              input logic       up);
        if (up)
            return (v == vmax) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0) ? vmax : v - 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_timer_dp_prescaler.sv
`default_nettype none
// ============================================================================
// Module : countdown_timer_dp_prescaler
// Divides the system clock to a one-cycle 10 ms tick; holds phase while disabled.
// Rev    : 1.0
// ============================================================================
module countdown_timer_dp_prescaler #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iEn,
    input  logic iClr,
    output logic oTick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge iClk) begin
        if (!iRst_n || iClr)
            cnt <= '0;
        else if (iEn)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign oTick = iEn && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/countdown_timer_dp.sv
`default_nettype none
// ============================================================================
// Module : countdown_timer_dp
// H:M:S.cs countdown datapath with preset editing; CDT_AUTO_RELOAD_EN selects periodic mode.
// Rev    : 1.0
// ============================================================================
module countdown_timer_dp
    import countdown_timer_dp_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int INIT_MIN = 1
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iRun_Stop,
    input  logic        iClear,
    input  logic [1:0]  iSel,
    input  logic        iInc,
    input  logic        iDec,
    output logic [6:0]  omSec,
    output logic [5:0]  oSec,
    output logic [5:0]  oMin,
    output logic [4:0]  oHour,
    output logic [1:0]  oState,
    output logic        oDone
);

    localparam logic [MIN_W-1:0] INIT_MIN_V = MIN_W'(INIT_MIN);

    cdt_state_e        state, state_nxt;
    logic [CS_W-1:0]   cs, cs_nxt, dec_cs;
    logic [SEC_W-1:0]  sec, sec_nxt, dec_sec, pre_sec, pre_sec_nxt;
    logic [MIN_W-1:0]  min, min_nxt, dec_min, pre_min, pre_min_nxt;
    logic [HOUR_W-1:0] hour, hour_nxt, dec_hour, pre_hour, pre_hour_nxt;
    logic [5:0]        sec_step, min_step, hour_step;
    logic              done_nxt, tick, b_cs, b_sec, b_min, dec_zero, count_zero, edit_req;

    countdown_timer_dp_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iEn    (state == CDT_RUN),
        .iClr   (iClear || state == CDT_IDLE || state == CDT_EXPIRED),
        .oTick  (tick)
    );

    // Borrow chain: hours never underflow because the all-zero result expires first.
    always_comb begin
        b_cs     = (cs == '0);
        b_sec    = b_cs && (sec == '0);
        b_min    = b_sec && (min == '0);
        dec_cs   = b_cs ? CS_MAX : cs - 1'b1;
        dec_sec  = b_cs ? ((sec == '0) ? SEC_MAX : sec - 1'b1) : sec;
        dec_min  = b_sec ? ((min == '0) ? MIN_MAX : min - 1'b1) : min;
        dec_hour = b_min ? hour - 1'b1 : hour;
    end

    assign dec_zero   = (dec_cs == '0) && (dec_sec == '0) && (dec_min == '0) && (dec_hour == '0);
    assign count_zero = (cs == '0) && (sec == '0) && (min == '0) && (hour == '0);
    assign edit_req   = (iInc ^ iDec) && (iSel != 2'd3);
    assign sec_step   = field_step(pre_sec, SEC_MAX, iInc);
    assign min_step   = field_step(pre_min, MIN_MAX, iInc);
    assign hour_step  = field_step({1'b0, pre_hour}, {1'b0, HOUR_MAX}, iInc);

    always_comb begin
        state_nxt    = state;
        cs_nxt       = cs;
        sec_nxt      = sec;
        min_nxt      = min;
        hour_nxt     = hour;
        pre_sec_nxt  = pre_sec;
        pre_min_nxt  = pre_min;
        pre_hour_nxt = pre_hour;
        done_nxt     = 1'b0;
        if (iClear) begin
            state_nxt = CDT_IDLE;
            cs_nxt    = '0;
            sec_nxt   = pre_sec;
            min_nxt   = pre_min;
            hour_nxt  = pre_hour;
        end else if (tick) begin
            if (dec_zero) begin
                done_nxt = 1'b1;
`ifdef CDT_AUTO_RELOAD_EN
                cs_nxt    = '0;
                sec_nxt   = pre_sec;
                min_nxt   = pre_min;
                hour_nxt  = pre_hour;
                state_nxt = ((pre_sec == '0) && (pre_min == '0) && (pre_hour == '0))
                            ? CDT_IDLE : CDT_RUN;
`else
                cs_nxt    = '0;
                sec_nxt   = '0;
                min_nxt   = '0;
                hour_nxt  = '0;
                state_nxt = CDT_EXPIRED;
`endif
            end else begin
                cs_nxt   = dec_cs;
                sec_nxt  = dec_sec;
                min_nxt  = dec_min;
                hour_nxt = dec_hour;
                if (!iRun_Stop)
                    state_nxt = CDT_PAUSE;
            end
        end else begin
            unique case (state)
                CDT_IDLE: begin
                    if (iRun_Stop && !count_zero) begin
                        state_nxt = CDT_RUN;
                    end else if (edit_req) begin
                        unique case (iSel)
                            SEL_SEC:  pre_sec_nxt  = sec_step;
                            SEL_MIN:  pre_min_nxt  = min_step;
                            SEL_HOUR: pre_hour_nxt = hour_step[HOUR_W-1:0];
                            default:  ;
                        endcase
                        cs_nxt   = '0;
                        sec_nxt  = pre_sec_nxt;
                        min_nxt  = pre_min_nxt;
                        hour_nxt = pre_hour_nxt;
                    end
                end
                CDT_RUN:     if (!iRun_Stop) state_nxt = CDT_PAUSE;
                CDT_PAUSE:   if (iRun_Stop)  state_nxt = CDT_RUN;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state    <= CDT_IDLE;
            cs       <= '0;
            sec      <= '0;
            min      <= INIT_MIN_V;
            hour     <= '0;
            pre_sec  <= '0;
            pre_min  <= INIT_MIN_V;
            pre_hour <= '0;
            oDone    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cs       <= cs_nxt;
            sec      <= sec_nxt;
            min      <= min_nxt;
            hour     <= hour_nxt;
            pre_sec  <= pre_sec_nxt;
            pre_min  <= pre_min_nxt;
            pre_hour <= pre_hour_nxt;
            oDone    <= done_nxt;
        end
    end

    assign omSec  = cs;
    assign oSec   = sec;
    assign oMin   = min;
    assign oHour  = hour;
    assign oState = state;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_dp.sv
`default_nettype none
// ============================================================================
// Module : tb_countdown_timer_dp
// Directed + random bench against a total-centisecond reference model.
// Rev    : 1.0
// ============================================================================
module tb_countdown_timer_dp;

    localparam int TDIV     = 4;
    localparam int INIT_MIN = 1;

    logic       clk = 1'b0;
    logic       rst_n, run_stop, clr, inc, dec;
    logic [1:0] sel;
    logic [6:0] omSec;
    logic [5:0] oSec, oMin;
    logic [4:0] oHour;
    logic [1:0] oState;
    logic       oDone;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: count kept as total centiseconds, preset as plain integers.
    int m_state, m_total, m_psc, m_ps, m_pm, m_ph;
    bit m_done;

    countdown_timer_dp #(.TICK_DIV(TDIV), .INIT_MIN(INIT_MIN)) dut (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .iRun_Stop (run_stop),
        .iClear    (clr),
        .iSel      (sel),
        .iInc      (inc),
        .iDec      (dec),
        .omSec     (omSec),
        .oSec      (oSec),
        .oMin      (oMin),
        .oHour     (oHour),
        .oState    (oState),
        .oDone     (oDone)
    );

    always #5 clk = ~clk;

    function automatic int ptot();
        return m_ph * 360000 + m_pm * 6000 + m_ps * 100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit rs, input bit c,
                              input int s, input bit i, input bit d);
        bit tick;
        bit nd;
        int ns, nt, np, delta;
        tick  = (m_state == 1) && (m_psc == TDIV - 1);
        ns    = m_state;
        nt    = m_total;
        np    = m_psc;
        nd    = 1'b0;
        delta = i ? 1 : -1;
        if (!r) begin
            m_ph = 0; m_pm = INIT_MIN; m_ps = 0;
            ns = 0; nt = INIT_MIN * 6000; np = 0;
        end else if (c) begin
            ns = 0; nt = ptot(); np = 0;
        end else begin
            if (m_state == 1)      np = (m_psc + 1) % TDIV;
            else if (m_state != 2) np = 0;
            if (tick) begin
                nt = m_total - 1;
                if (nt == 0) begin
                    nd = 1'b1;
`ifdef CDT_AUTO_RELOAD_EN
                    nt = ptot();
                    ns = (nt == 0) ? 0 : 1;
`else
                    ns = 3;
`endif
                end else if (!rs) begin
                    ns = 2;
                end
            end else if (m_state == 0) begin
                if (rs && m_total != 0) begin
                    ns = 1;
                end else if ((i ^ d) && s != 3) begin
                    if (s == 0)      m_ps = (m_ps + 60 + delta) % 60;
                    else if (s == 1) m_pm = (m_pm + 60 + delta) % 60;
                    else             m_ph = (m_ph + 24 + delta) % 24;
                    nt = ptot();
                end
            end else if (m_state == 1 && !rs) begin
                ns = 2;
            end else if (m_state == 2 && rs) begin
                ns = 1;
            end
        end
        m_state = ns; m_total = nt; m_psc = np; m_done = nd;
    endtask

    task automatic cyc(input bit r, input bit rs, input bit c,
                       input int s, input bit i, input bit d);
        rst_n = r; run_stop = rs; clr = c; sel = 2'(s); inc = i; dec = d;
        model_step(r, rs, c, s, i, d);
        @(posedge clk);
        #1;
        chk("cycle", {5'd0, omSec, oSec, oMin, oHour, oState, oDone},
            {5'd0, 7'(m_total % 100), 6'((m_total / 100) % 60), 6'((m_total / 6000) % 60),
             5'(m_total / 360000), 2'(m_state), m_done});
    endtask

    initial begin
        int done_cnt;
        bit rs_r;
        rst_n = 1'b0; run_stop = 1'b0; clr = 1'b0; sel = 2'd0; inc = 1'b0; dec = 1'b0;

        // Reset and first tick
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("reset_val", {omSec, oSec, oMin, oHour, oState, oDone}, {7'd0, 6'd0, 6'd1, 5'd0, 2'd0, 1'b0});
        for (int k = 0; k < 5; k++) cyc(1, 1, 0, 0, 0, 0);
        chk("first_tick", {omSec, oSec, oMin, oHour, oState}, {7'd99, 6'd59, 6'd0, 5'd0, 2'd1});

        // Pause/resume and ignored edit while running
        for (int k = 0; k < 6; k++)  cyc(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 0);

        // Clear landing on a tick cycle
        for (int k = 0; k < 8 && !(m_state == 1 && m_psc == TDIV - 1); k++) cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("clear_on_tick", {omSec, oSec, oMin, oHour, oState}, {7'd0, 6'd0, 6'd1, 5'd0, 2'd0});

        // Edit wrap cases
        cyc(1, 0, 0, 0, 0, 1);
        chk("sec_dec_wrap", {omSec, oSec, oMin}, {7'd0, 6'd59, 6'd1});
        cyc(1, 0, 0, 2, 0, 1);
        chk("hour_dec_wrap", {27'd0, oHour}, {27'd0, 5'd23});
        cyc(1, 0, 0, 2, 1, 0);
        chk("hour_inc_wrap", {27'd0, oHour}, {27'd0, 5'd0});
        cyc(1, 0, 0, 0, 1, 1);
        chk("inc_dec_same", {26'd0, oSec}, {26'd0, 6'd59});
        cyc(1, 0, 0, 3, 1, 0);
        chk("sel_none", {oSec, oMin, oHour}, {6'd59, 6'd1, 5'd0});

        // Borrow through all fields: 01:00:00.00 -> 00:59:59.99
        cyc(1, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 2, 1, 0);
        chk("preset_1h", {omSec, oSec, oMin, oHour}, {7'd0, 6'd0, 6'd0, 5'd1});
        for (int k = 0; k < 5; k++) cyc(1, 1, 0, 0, 0, 0);
        chk("borrow", {omSec, oSec, oMin, oHour}, {7'd99, 6'd59, 6'd59, 5'd0});
        cyc(1, 0, 1, 0, 0, 0);

        // Zero count cannot start; 1 s preset runs to expiry
        cyc(1, 0, 0, 2, 0, 1);
        cyc(1, 1, 0, 0, 0, 0);
        chk("zero_no_start", {30'd0, oState}, {30'd0, 2'd0});
        cyc(1, 0, 0, 0, 1, 0);
        done_cnt = 0;
        for (int k = 0; k < 430; k++) begin
            cyc(1, 1, 0, 0, (k == 50), 0);
            if (oDone === 1'b1) done_cnt++;
        end
        chk("done_pulses", 32'(done_cnt), 32'd1);
`ifdef CDT_AUTO_RELOAD_EN
        chk("state_after_expiry", {30'd0, oState}, {30'd0, 2'd1});
`else
        chk("state_after_expiry", {30'd0, oState}, {30'd0, 2'd3});
        chk("expired_hold", {omSec, oSec, oMin, oHour}, 24'd0);
`endif
        cyc(1, 0, 1, 0, 0, 0);

        // Randomized traffic, including occasional reset and clear
        rs_r = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            int s;
            if ($urandom % 16 == 0) rs_r = ~rs_r;
            s = ($urandom % 2 == 0) ? 0 : int'($urandom % 4);
            cyc(($urandom % 300) != 0, rs_r, ($urandom % 40) == 0, s,
                ($urandom % 6) == 0, ($urandom % 6) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
